// File: rtl/firebird_rf_pkg.sv
// rtl/firebird_rf_pkg.sv - shared constants and helpers for the Firebird register file
package firebird_rf_pkg;

    localparam int XLEN_DEF = 32;
    localparam int REG_ZERO = 0;

    // Address width for a given register count; at least one bit.
    function automatic int calc_aw(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

endpackage

// File: rtl/firebird_rf_pend_cnt.sv
// rtl/firebird_rf_pend_cnt.sv - saturating pending-write counter for one register
module firebird_rf_pend_cnt #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          zero,
    output logic          full,
    output logic          underflow
);

    localparam logic [CW-1:0] CMAX = '1;

    assign zero      = (count == '0);
    assign full      = (count == CMAX);
    // A retire with nothing pending, unless an issue in the same cycle covers it.
    assign underflow = dec && !inc && zero;

    // Up/down count that never wraps; a simultaneous inc and dec cancel.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !dec && !full) begin
            count <= count + CW'(1);
        end else if (dec && !inc && !zero) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/firebird_regfile_sb.sv
// rtl/firebird_regfile_sb.sv - multi-port register file with pending-write scoreboard (option: FIREBIRD_RF_BYPASS_EN)
module firebird_regfile_sb
    import firebird_rf_pkg::*;
#(
    parameter  int XLEN    = XLEN_DEF,
    parameter  int NREGS   = 32,
    parameter  int NRPORTS = 2,
    parameter  int CW      = 2,
    localparam int AW      = calc_aw(NREGS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NRPORTS*AW-1:0]   raddr,
    output logic [NRPORTS*XLEN-1:0] rdata,
    output logic [NRPORTS-1:0]      rbusy,
    input  logic                    issue_valid,
    input  logic [AW-1:0]           issue_rd,
    output logic                    issue_ready,
    input  logic                    we,
    input  logic [AW-1:0]           waddr,
    input  logic [XLEN-1:0]         wdata,
    output logic                    wb_underflow
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

    logic [XLEN-1:0] regs     [NREGS];
    logic [CW-1:0]   cnt      [NREGS];
    logic            zero_vec [NREGS];
    logic            full_vec [NREGS];
    logic            uf_vec   [NREGS];

    logic wb_fire;
    logic issue_acc;
    logic same_reg;
    logic any_uf;

    // Issue and writeback are both suppressed while reset is held.
    assign wb_fire     = !reset && we && (waddr != ZERO_ADDR);
    assign issue_ready = (issue_rd == ZERO_ADDR) || !full_vec[issue_rd];
    assign issue_acc   = !reset && issue_valid && issue_ready && (issue_rd != ZERO_ADDR);
    assign same_reg    = issue_acc && wb_fire && (issue_rd == waddr);

    // x0 has no counter: it is never pending and never underflows.
    assign cnt[0]      = '0;
    assign zero_vec[0] = 1'b1;
    assign full_vec[0] = 1'b0;
    assign uf_vec[0]   = 1'b0;

    for (genvar i = 1; i < NREGS; i++) begin : g_cnt
        firebird_rf_pend_cnt #(
            .CW(CW)
        ) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .inc       (issue_acc && (issue_rd == AW'(i))),
            .dec       (wb_fire && (waddr == AW'(i))),
            .count     (cnt[i]),
            .zero      (zero_vec[i]),
            .full      (full_vec[i]),
            .underflow (uf_vec[i])
        );
    end

    // Any register retiring with nothing pending this cycle.
    always_comb begin
        any_uf = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            any_uf = any_uf | uf_vec[r];
        end
    end

    // Sticky underflow flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_underflow <= 1'b0;
        end else if (any_uf) begin
            wb_underflow <= 1'b1;
        end
    end

    // Register storage; x0 is never written so it stays zero after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else if (wb_fire) begin
            regs[waddr] <= wdata;
        end
    end

    for (genvar k = 0; k < NRPORTS; k++) begin : g_rd
        logic [AW-1:0] a;
        logic          hit;

        assign a = raddr[k*AW +: AW];
`ifdef FIREBIRD_RF_BYPASS_EN
        assign hit = wb_fire && (a == waddr);
`else
        assign hit = 1'b0;
`endif
        // A forwarded read is busy only if writes remain after this retire.
        assign rdata[k*XLEN +: XLEN] = (a == ZERO_ADDR) ? '0 : (hit ? wdata : regs[a]);
        assign rbusy[k] = (a == ZERO_ADDR) ? 1'b0 :
                          hit ? (same_reg ? !zero_vec[a] : (cnt[a] > CW'(1))) :
                          !zero_vec[a];
    end

endmodule

// File: tb/tb_firebird_regfile_sb.sv
// tb/tb_firebird_regfile_sb.sv - randomized self-checking bench against a behavioural register file model
module tb_firebird_regfile_sb;

    localparam int XLEN    = 32;
    localparam int NREGS   = 32;
    localparam int NRPORTS = 2;
    localparam int CW      = 2;
    localparam int AW      = 5;
    localparam int CMAX    = (1 << CW) - 1;
`ifdef FIREBIRD_RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NRPORTS*AW-1:0]   raddr;
    logic [NRPORTS*XLEN-1:0] rdata;
    logic [NRPORTS-1:0]      rbusy;
    logic                    issue_valid;
    logic [AW-1:0]           issue_rd;
    logic                    issue_ready;
    logic                    we;
    logic [AW-1:0]           waddr;
    logic [XLEN-1:0]         wdata;
    logic                    wb_underflow;

    int tests = 0;
    int fails = 0;

    logic [XLEN-1:0] mreg [NREGS];
    int              mcnt [NREGS];
    bit              muf;

    always #5 clk = ~clk;

    firebird_regfile_sb dut (
        .clk          (clk),
        .reset        (reset),
        .raddr        (raddr),
        .rdata        (rdata),
        .rbusy        (rbusy),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_ready  (issue_ready),
        .we           (we),
        .waddr        (waddr),
        .wdata        (wdata),
        .wb_underflow (wb_underflow)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        return (issue_rd == 0) || (mcnt[issue_rd] != CMAX);
    endfunction

    // Pending count register r will hold after the coming edge.
    function automatic int next_cnt(input int r);
        bit acc = !reset && issue_valid && model_ready() && (issue_rd != 0) && (int'(issue_rd) == r);
        bit wb  = !reset && we && (waddr != 0) && (int'(waddr) == r);
        if (acc && wb) return mcnt[r];
        if (acc)       return mcnt[r] + 1;
        if (wb)        return (mcnt[r] == 0) ? 0 : mcnt[r] - 1;
        return mcnt[r];
    endfunction

    task automatic compare_all();
        for (int k = 0; k < NRPORTS; k++) begin
            int              a;
            bit              hit;
            logic [XLEN-1:0] erd;
            bit              ebz;
            a   = int'(raddr[k*AW +: AW]);
            hit = BYP && !reset && we && (waddr != 0) && (int'(waddr) == a);
            erd = (a == 0) ? '0 : (hit ? wdata : mreg[a]);
            ebz = (a == 0) ? 1'b0 : (hit ? (next_cnt(a) != 0) : (mcnt[a] != 0));
            chk($sformatf("rdata[%0d] x%0d", k, a), 64'(rdata[k*XLEN +: XLEN]), 64'(erd));
            chk($sformatf("rbusy[%0d] x%0d", k, a), 64'(rbusy[k]), 64'(ebz));
        end
        chk("issue_ready", 64'(issue_ready), 64'(model_ready()));
        chk("wb_underflow", 64'(wb_underflow), 64'(muf));
    endtask

    task automatic model_edge();
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                mreg[r] = '0;
                mcnt[r] = 0;
            end
            muf = 1'b0;
        end else begin
            bit acc = issue_valid && model_ready() && (issue_rd != 0);
            bit wb  = we && (waddr != 0);
            if (wb) mreg[waddr] = wdata;
            if (!(acc && wb && issue_rd == waddr)) begin
                if (acc) mcnt[issue_rd] = mcnt[issue_rd] + 1;
                if (wb) begin
                    if (mcnt[waddr] == 0) muf = 1'b1;
                    else mcnt[waddr] = mcnt[waddr] - 1;
                end
            end
        end
    endtask

    task automatic set_in(input bit rst, input bit iv, input int rd, input bit w,
                          input int wa, input logic [XLEN-1:0] wd, input int r0, input int r1);
        @(negedge clk);
        reset       = rst;
        issue_valid = iv;
        issue_rd    = AW'(rd);
        we          = w;
        waddr       = AW'(wa);
        wdata       = wd;
        raddr       = {AW'(r1), AW'(r0)};
        #1;
        compare_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
    endtask

    initial begin
        reset = 1'b1; issue_valid = 1'b0; issue_rd = '0; we = 1'b0;
        waddr = '0; wdata = '0; raddr = '0;
        tick();

        // Reset after arbitrary writes and issues
        set_in(0, 0, 0, 1, 4, 32'h11, 4, 6);  tick();
        set_in(0, 1, 6, 1, 9, 32'h22, 4, 6);  tick();
        set_in(1, 1, 6, 1, 4, 32'h33, 4, 6);  tick();
        set_in(0, 0, 0, 0, 0, 0, 4, 6);
        chk("rst rdata", 64'(rdata), 64'h0);
        chk("rst rbusy", 64'(rbusy), 64'h0);
        chk("rst underflow", 64'(wb_underflow), 64'h0);
        chk("rst ready", 64'(issue_ready), 64'h1);
        tick();

        // Issue x5, retire two cycles later
        set_in(0, 1, 5, 0, 0, 0, 5, 5);  tick();
        set_in(0, 0, 0, 0, 0, 0, 5, 5);
        chk("x5 busy pending", 64'(rbusy[0]), 64'h1);
        tick();
        set_in(0, 0, 0, 1, 5, 32'hDEADBEEF, 5, 5);
        if (BYP) begin
            chk("x5 fwd data", 64'(rdata[31:0]), 64'hDEADBEEF);
            chk("x5 fwd busy", 64'(rbusy[0]), 64'h0);
        end else begin
            chk("x5 wb busy", 64'(rbusy[0]), 64'h1);
        end
        tick();
        set_in(0, 0, 0, 0, 0, 0, 5, 5);
        chk("x5 data after", 64'(rdata[63:32]), 64'hDEADBEEF);
        chk("x5 busy after", 64'(rbusy), 64'h0);
        tick();

        // Saturate x7
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1, 7, 0, 0, 0, 7, 0); tick();
        end
        set_in(0, 1, 7, 0, 0, 0, 7, 0);
        chk("x7 ready full", 64'(issue_ready), 64'h0);
        tick();
        set_in(0, 0, 0, 1, 7, 32'h7, 7, 0); tick();
        set_in(0, 0, 0, 1, 7, 32'h8, 7, 0); tick();
        set_in(0, 0, 0, 1, 7, 32'h9, 7, 0);
        chk("x7 busy last wb", 64'(rbusy[0]), BYP ? 64'h0 : 64'h1);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 7, 0);
        chk("x7 busy clear", 64'(rbusy[0]), 64'h0);
        chk("x7 no underflow", 64'(wb_underflow), 64'h0);
        tick();

        // x0 writes and issues are inert
        set_in(0, 1, 0, 1, 0, 32'h12345678, 0, 0);
        chk("x0 ready", 64'(issue_ready), 64'h1);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        chk("x0 data", 64'(rdata), 64'h0);
        chk("x0 busy", 64'(rbusy), 64'h0);
        chk("x0 underflow", 64'(wb_underflow), 64'h0);
        tick();

        // Same-cycle issue and retire at zero count, then a true underflow
        set_in(0, 1, 10, 1, 10, 32'h77, 10, 9); tick();
        set_in(0, 0, 0, 0, 0, 0, 10, 9);
        chk("x10 no flag", 64'(wb_underflow), 64'h0);
        chk("x10 busy", 64'(rbusy[0]), 64'h0);
        chk("x10 data", 64'(rdata[31:0]), 64'h77);
        tick();
        set_in(0, 0, 0, 1, 9, 32'hA5, 9, 9); tick();
        set_in(0, 0, 0, 0, 0, 0, 9, 9);
        chk("x9 data", 64'(rdata[31:0]), 64'hA5);
        chk("x9 underflow", 64'(wb_underflow), 64'h1);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 1, 2);
        chk("underflow sticky", 64'(wb_underflow), 64'h1);
        tick();

        // Issue and retire x3 together at count 1
        set_in(0, 1, 3, 0, 0, 0, 3, 3); tick();
        set_in(0, 1, 3, 1, 3, 32'hC0FFEE, 3, 3); tick();
        set_in(0, 0, 0, 0, 0, 0, 3, 3);
        chk("x3 busy both", 64'(rbusy), 64'h3);
        chk("x3 port0", 64'(rdata[31:0]), 64'hC0FFEE);
        chk("x3 port1", 64'(rdata[63:32]), 64'hC0FFEE);
        tick();

        // Randomized traffic on a narrow address window to force hazards
        for (int n = 0; n < 3000; n++) begin
            set_in($urandom_range(0, 99) == 0,
                   $urandom_range(0, 9) < 6, $urandom_range(0, 15),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom(),
                   $urandom_range(0, 15), $urandom_range(0, 15));
            tick();
        end

        set_in(1, 0, 0, 0, 0, 0, 0, 0); tick();
        set_in(0, 0, 0, 0, 0, 0, 3, 9);
        chk("final rst data", 64'(rdata), 64'h0);
        chk("final rst busy", 64'(rbusy), 64'h0);
        chk("final rst underflow", 64'(wb_underflow), 64'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/firebird_regfile_sb.md
Name: firebird_regfile_sb

Overview:
Parametrised multi-read-port integer register file with a per-register pending-write scoreboard, for the pipelined Firebird core.
- Decode issues a destination register, which marks it pending; writeback retires it.
- Read ports return data plus a busy flag so hazard logic can stall.
- x0 is hardwired zero and is never pending.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (power of 2, >=2); AW = $clog2(NREGS)
NRPORTS, 2, number of independent read ports
CW, 2, pending-counter width; max in-flight writes per register = 2^CW-1

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
raddr  in  NRPORTS*AW  packed read addresses; port k = raddr[k*AW +: AW]
rdata  out  NRPORTS*XLEN  packed read data, combinational
rbusy  out  NRPORTS  port k register has pending writes
issue_valid  in  1  decode issues an instruction writing issue_rd
issue_rd  in  AW  destination register being issued
issue_ready  out  1  issue_rd counter not saturated (combinational)
we  in  1  writeback enable
waddr  in  AW  writeback register
wdata  in  XLEN  writeback data
wb_underflow  out  1  sticky: writeback hit a register with zero pending count

Behaviour:
- Reset, one cycle, synchronous:
  - All registers clear to 0.
  - All pending counters clear to 0.
  - wb_underflow clears to 0.
  - While reset is high, issue and writeback are ignored. Reset mid-flight discards all pending state.
- Read path:
  - rdata[k] = 0 when raddr[k]==0; otherwise reg[raddr[k]].
  - Zero-latency combinational read of the registered state.
  - rbusy[k] = (cnt[raddr[k]] != 0); always 0 for x0.
- Write path:
  - On posedge with we=1 and waddr!=0, reg[waddr] <= wdata.
  - Writes to x0 are discarded.
  - Write data is visible on reads the following cycle (see optional feature).
- Issue:
  - Accepted when issue_valid && issue_ready && issue_rd!=0; cnt[issue_rd] increments.
  - issue_ready = (issue_rd==0) || (cnt[issue_rd] != 2^CW-1).
  - issue_valid with issue_ready=0 is ignored: no state change, and no error is raised.
  - issue_rd==0 is always ready and changes nothing.
- Writeback retire:
  - we=1 and waddr!=0: cnt[waddr] decrements if nonzero.
  - If cnt[waddr] is already 0: data is still written, the counter stays 0, and wb_underflow sets (sticky until reset).
- Simultaneous accepted issue and writeback:
  - Same register: counter unchanged (+1-1). If the counter was 0, underflow is not flagged, because the issue covers it.
  - Different registers: both updates apply independently.
- Saturation:
  - A counter never wraps. Increments stop at 2^CW-1 via issue_ready.
  - Decrements stop at 0.
- Latency: scoreboard updates are visible on rbusy and issue_ready the cycle after the clock edge.

Optional Feature:
Macro FIREBIRD_RF_BYPASS_EN.
- Defined:
  - Write-to-read forwarding: if we=1, waddr!=0 and raddr[k]==waddr, then rdata[k]=wdata in the same cycle.
  - rbusy[k] reflects the retiring write: it is 0 if cnt==1 and no same-register issue occurs that cycle.
  - The underflow case forwards data with rbusy 0.
- Undefined:
  - No forwarding; rdata and rbusy come from registered state only.
  - Written data is readable one cycle after writeback.

Decomposition:
- Shared package firebird_rf_pkg holds:
  - XLEN default;
  - function for AW from NREGS;
  - REG_ZERO constant (x0 index).
- One natural sub-module, firebird_rf_pend_cnt: a CW-bit saturating up/down counter with inc, dec, zero and full outputs and underflow detect.
  - Instantiated NREGS-1 times via generate; index 0 is tied off to zero.

Test Plan:
- Reset after arbitrary writes -> all ports read 0, rbusy=0, wb_underflow=0, issue_ready=1.
- Issue rd=5, then writeback x5=0xDEADBEEF two cycles later -> rbusy for x5 is 1 until the writeback edge. The cycle after, rdata=0xDEADBEEF and rbusy=0. With BYPASS_EN, rdata=0xDEADBEEF and rbusy=0 in the writeback cycle itself.
- Three issues to x7 (CW=2) -> issue_ready=0 for rd=7. A fourth issue is ignored; cnt stays 3. Three writebacks are needed to clear rbusy.
- Write x0=0x12345678, and issue rd=0 -> reads of x0 return 0, rbusy=0, no underflow.
- Writeback x9=0xA5 with no prior issue -> data is written, wb_underflow=1 and stays 1 until reset. A same-cycle issue+writeback on x10 with cnt 0 leaves cnt 0 and does not flag.
- Same-cycle issue x3 and writeback x3 at cnt=1 -> cnt stays 1 and rbusy stays 1. Both ports reading x3 return identical data.
